sample_sequencer: RTL and testbench
===================================

Name: sample_sequencer

Overview:
Two-track step sequencer and voice arbiter for the keyboard sampler. It records one-hot key events from the PS/2 keyboard tracker into two 9-step tracks and plays them back on a shared tempo beat. It arbitrates live keys and both tracks onto the single voice output that drives LEDR and the tone generator. It sits between keyboard_tracker and the top-level sampler output logic.

Parameters:
NUM_STEPS, 9, maximum notes per track (1..15)
TICKS_PER_STEP, 12500000, clock cycles per playback step (0.25 s at 50 MHz), minimum 2

Ports:
clock  input  1  system clock (CLOCK_50)
resetn  input  1  asynchronous active-low reset
key_pressed  input  9  level key vector {q,w,e,r,t,y,u,i,o}, bit 8 = q
rec_en  input  1  record enable, level
rec_track  input  1  track selected for recording (0 = track1, 1 = track2)
play_en  input  2  per-track play enable, level; bit 0 = track1
loop_en  input  1  playing tracks wrap to step 0 instead of stopping
note  output  4  arbitrated voice: 0 = silence, 1..9 = q..o
led  output  3  LED code of note: q 001, w 010, e 100, r 110, t..o 011, silence 000
src  output  2  voice owner: 00 none, 01 live, 10 track1, 11 track2
track_len  output  8  {len2[3:0], len1[3:0]} recorded lengths
rec_full  output  1  selected track full while recording
play_done  output  2  one-cycle pulse per track when a non-looping playback ends

Behaviour:
- Reset (async, resetn=0): all outputs 0; lengths, pointers and tempo counter 0; both tracks IDLE; edge-detect registers 0. Memory contents are don't-care and unreachable while length is 0.
- Key decode: valid only if key_pressed is exactly one-hot. Index = 9 - bit position (q=1 .. o=9). Zero or multi-hot vector = no key.
- Key event: a cycle where the decoded index is nonzero and differs from the previous cycle's index. Holding a key is one event.
- Per-track FSM, states IDLE, RECORD, PLAY:
  - IDLE->RECORD on rec_en rising edge with rec_track selecting this track. Length cleared to 0 in the same cycle.
  - RECORD: each key event writes the index at address len, then len increments. At len == NUM_STEPS, further events are ignored and rec_full=1.
  - RECORD->IDLE when rec_en falls or rec_track changes; len is kept.
  - IDLE->PLAY on play_en[n] rising edge if len>0 and the track is not recording. If len==0, stay IDLE with no done pulse.
  - PLAY->IDLE when play_en[n] falls (no done pulse) or at end of sequence (see below).
  - Record request on a playing track: playback aborts without a done pulse and the track enters RECORD. Record wins.
- Tempo: one shared counter 0..TICKS_PER_STEP-1. It runs only while at least one track is in PLAY and holds 0 otherwise.
  - A start while no track is playing clears the counter. A start while another track plays joins the running beat.
  - Beat = counter at TICKS_PER_STEP-1. On a beat, each PLAY track with ptr < len-1 increments ptr.
  - On a beat at ptr == len-1: if loop_en, ptr <- 0; else go IDLE and assert play_done[n] for one cycle.
  - ptr <- 0 on PLAY entry.
- Track voice: mem[ptr] while in PLAY, else 0. Step 0 is visible on the cycle after the start edge is sampled, i.e. 1-cycle latency.
- Arbitration (registered, 1-cycle latency from inputs or state to note/led/src), priority live > track1 > track2:
  - live is any nonzero decoded key, whether or not recording.
  - A lower-priority track keeps advancing while masked.
- Widths: len and ptr are 4 bits. ptr never exceeds len-1 and never wraps past NUM_STEPS-1.

Test Plan:
- Record: TICKS_PER_STEP=4. Reset, rec_en=1, rec_track=0, press q,e,e(released between),o -> len1=4 and mem1=1,3,3,9. Holding w for 10 cycles -> len1=5, a single write.
- Full: press 11 distinct events into track2 -> len2=9, rec_full=1, 10th and 11th events not written, len2 stays 9.
- Playback: play_en=01, loop_en=0 on track {1,3,3,9} -> note=1 for 4 cycles, then 3 for 8, then 9 for 4, then 0. play_done[0] pulses once; led sequence 001,100,100,011.
- Loop and arbitration: loop_en=1, both tracks playing -> src=10 and note follows track1, wrapping to step 0 after step len-1. Press r mid-step -> note=4, led=110, src=01 next cycle. Release r -> track1 note resumes at its advanced ptr.
- Record over play: track1 playing, rec_en=1 with rec_track=0 -> next cycle track1 in RECORD, len1=0, note=0, no play_done pulse.
- Async reset mid-playback: resetn=0 between clock edges -> note/led/src/track_len/rec_full/play_done=0 immediately. After release, play_en edge on track1 -> stays IDLE because len1=0.

Source files
------------

// File: rtl/sample_sequencer_if.sv
// Control inputs and voice outputs exchanged between the keyboard side and the sequencer.
interface sample_sequencer_if;
    logic [8:0] key_pressed;
    logic       rec_en;
    logic       rec_track;
    logic [1:0] play_en;
    logic       loop_en;
    logic [3:0] note;
    logic [2:0] led;
    logic [1:0] src;
    logic [7:0] track_len;
    logic       rec_full;
    logic [1:0] play_done;

    modport master (
        output key_pressed, rec_en, rec_track, play_en, loop_en,
        input  note, led, src, track_len, rec_full, play_done
    );

    modport slave (
        input  key_pressed, rec_en, rec_track, play_en, loop_en,
        output note, led, src, track_len, rec_full, play_done
    );
endinterface

// File: rtl/sample_sequencer.sv
// Two-track step sequencer: records one-hot key events, replays them on a shared beat,
// and arbitrates live keys and both tracks onto one registered voice output.
module sample_sequencer #(
    parameter int NUM_STEPS      = 9,
    parameter int TICKS_PER_STEP = 12500000
) (
    input  logic              clock,
    input  logic              resetn,
    sample_sequencer_if.slave bus
);
    localparam int            TW        = $clog2(TICKS_PER_STEP);
    localparam logic [TW-1:0] LAST_TICK = TW'(TICKS_PER_STEP - 1);
    localparam logic [3:0]    MAX_LEN   = 4'(NUM_STEPS);

    typedef enum logic [1:0] {S_IDLE, S_RECORD, S_PLAY} state_t;

    logic [3:0]    w_key_idx;
    logic [3:0]    r_prev_idx;
    logic          r_rec_en_d;
    logic          r_rec_track_d;
    logic [1:0]    r_play_en_d;
    logic          w_key_event;
    logic          w_rec_rise;
    logic          w_rec_stop;

    logic [TW-1:0] r_tick;
    logic [TW-1:0] w_tick_next;
    logic          w_beat;
    logic [1:0]    w_in_play;
    logic [1:0]    w_play_next;
    logic [1:0]    w_full;
    logic [1:0]    w_done;
    logic [3:0]    w_voice [2];
    logic [3:0]    w_len   [2];

    logic [3:0]    r_note;
    logic [3:0]    w_note_next;
    logic [2:0]    r_led;
    logic [2:0]    w_led_next;
    logic [1:0]    r_src;
    logic [1:0]    w_src_next;
    logic [1:0]    r_play_done;

    // Only an exactly one-hot vector names a key; q sits in bit 8 and maps to index 1.
    always_comb begin
        w_key_idx = 4'd0;
        if ($onehot(bus.key_pressed)) begin
            for (int i = 0; i < 9; i++) begin
                if (bus.key_pressed[i]) w_key_idx = 4'(9 - i);
            end
        end
    end

    assign w_key_event = (w_key_idx != 4'd0) && (w_key_idx != r_prev_idx);
    assign w_rec_rise  = bus.rec_en && !r_rec_en_d;
    assign w_rec_stop  = !bus.rec_en || (bus.rec_track != r_rec_track_d);

    // Shared beat: counts only while some track plays; a start from silence begins at 0.
    assign w_beat = (|w_in_play) && (r_tick == LAST_TICK);

    always_comb begin
        w_tick_next = '0;
        if ((|w_in_play) && (|w_play_next) && !w_beat) w_tick_next = r_tick + TW'(1);
    end

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_track
        state_t     r_state;
        state_t     w_state_next;
        logic [3:0] r_len;
        logic [3:0] w_len_next;
        logic [3:0] r_ptr;
        logic [3:0] w_ptr_next;
        logic       w_wr;
        logic       w_end;
        logic       w_rec_req;
        logic       w_play_rise;
        logic [3:0] r_mem [NUM_STEPS];

        assign w_rec_req   = w_rec_rise && (bus.rec_track == 1'(gi));
        assign w_play_rise = bus.play_en[gi] && !r_play_en_d[gi];

        always_comb begin
            w_state_next = r_state;
            w_len_next   = r_len;
            w_ptr_next   = r_ptr;
            w_wr         = 1'b0;
            w_end        = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_rec_req) begin
                        w_state_next = S_RECORD;
                        w_len_next   = 4'd0;
                    end else if (w_play_rise && (r_len != 4'd0)) begin
                        w_state_next = S_PLAY;
                        w_ptr_next   = 4'd0;
                    end
                end
                S_RECORD: begin
                    if (w_rec_stop) begin
                        w_state_next = S_IDLE;
                    end else if (w_key_event && (r_len < MAX_LEN)) begin
                        w_wr       = 1'b1;
                        w_len_next = r_len + 4'd1;
                    end
                end
                S_PLAY: begin
                    // A record request aborts playback silently.
                    if (w_rec_req) begin
                        w_state_next = S_RECORD;
                        w_len_next   = 4'd0;
                        w_ptr_next   = 4'd0;
                    end else if (!bus.play_en[gi]) begin
                        w_state_next = S_IDLE;
                    end else if (w_beat) begin
                        if (r_ptr < (r_len - 4'd1)) begin
                            w_ptr_next = r_ptr + 4'd1;
                        end else if (bus.loop_en) begin
                            w_ptr_next = 4'd0;
                        end else begin
                            w_state_next = S_IDLE;
                            w_end        = 1'b1;
                        end
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                r_state <= S_IDLE;
                r_len   <= 4'd0;
                r_ptr   <= 4'd0;
            end else begin
                r_state <= w_state_next;
                r_len   <= w_len_next;
                r_ptr   <= w_ptr_next;
            end
        end

        // Step storage carries no reset; only addresses below len are ever read.
        always_ff @(posedge clock) begin
            if (w_wr) r_mem[r_len] <= w_key_idx;
        end

        assign w_in_play[gi]   = (r_state == S_PLAY);
        assign w_play_next[gi] = (w_state_next == S_PLAY);
        assign w_voice[gi]     = (r_state == S_PLAY) ? r_mem[r_ptr] : 4'd0;
        assign w_len[gi]       = r_len;
        assign w_full[gi]      = (r_state == S_RECORD) && (r_len == MAX_LEN);
        assign w_done[gi]      = w_end;
    end

    // Live key beats track1, which beats track2; masked tracks keep stepping.
    always_comb begin
        w_note_next = 4'd0;
        w_src_next  = 2'b00;
        if (w_key_idx != 4'd0) begin
            w_note_next = w_key_idx;
            w_src_next  = 2'b01;
        end else if (w_voice[0] != 4'd0) begin
            w_note_next = w_voice[0];
            w_src_next  = 2'b10;
        end else if (w_voice[1] != 4'd0) begin
            w_note_next = w_voice[1];
            w_src_next  = 2'b11;
        end
        case (w_note_next)
            4'd0:    w_led_next = 3'b000;
            4'd1:    w_led_next = 3'b001;
            4'd2:    w_led_next = 3'b010;
            4'd3:    w_led_next = 3'b100;
            4'd4:    w_led_next = 3'b110;
            default: w_led_next = 3'b011;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_prev_idx    <= 4'd0;
            r_rec_en_d    <= 1'b0;
            r_rec_track_d <= 1'b0;
            r_play_en_d   <= 2'b00;
            r_tick        <= '0;
            r_note        <= 4'd0;
            r_led         <= 3'b000;
            r_src         <= 2'b00;
            r_play_done   <= 2'b00;
        end else begin
            r_prev_idx    <= w_key_idx;
            r_rec_en_d    <= bus.rec_en;
            r_rec_track_d <= bus.rec_track;
            r_play_en_d   <= bus.play_en;
            r_tick        <= w_tick_next;
            r_note        <= w_note_next;
            r_led         <= w_led_next;
            r_src         <= w_src_next;
            r_play_done   <= w_done;
        end
    end

    assign bus.note      = r_note;
    assign bus.led       = r_led;
    assign bus.src       = r_src;
    assign bus.track_len = {w_len[1], w_len[0]};
    assign bus.rec_full  = |w_full;
    assign bus.play_done = r_play_done;
endmodule

// File: tb/tb_sample_sequencer.sv
// Self-checking bench for sample_sequencer: recording, fill limit, playback, looping,
// arbitration, record-over-play and asynchronous reset, using a per-cycle scoreboard.
module tb_sample_sequencer;
    logic clk    = 1'b0;
    logic resetn = 1'b1;
    int   n_vec  = 0;
    int   n_err  = 0;

    typedef struct packed {
        logic [3:0] note;
        logic [1:0] src;
        logic [1:0] done;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] seq1 [4] = '{4'd1, 4'd3, 4'd3, 4'd9};

    sample_sequencer_if bus();

    sample_sequencer #(
        .NUM_STEPS      (9),
        .TICKS_PER_STEP (4)
    ) dut (
        .clock  (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] led_of(input logic [3:0] n);
        case (n)
            4'd0:    return 3'b000;
            4'd1:    return 3'b001;
            4'd2:    return 3'b010;
            4'd3:    return 3'b100;
            4'd4:    return 3'b110;
            default: return 3'b011;
        endcase
    endfunction

    function automatic logic [8:0] key_of(input int idx);
        logic [8:0] one;
        one = 9'd1;
        if (idx == 0) return 9'd0;
        return one << (9 - idx);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.key_pressed = 9'd0;
        bus.rec_en      = 1'b0;
        bus.rec_track   = 1'b0;
        bus.play_en     = 2'b00;
        bus.loop_en     = 1'b0;
        #1 resetn = 1'b0;
        cyc(2);
        n_vec++; if (bus.note !== 4'd0)      begin n_err++; $display("FAIL reset_note got %0d want 0", bus.note); end
        n_vec++; if (bus.led !== 3'b000)     begin n_err++; $display("FAIL reset_led got %b want 000", bus.led); end
        n_vec++; if (bus.src !== 2'b00)      begin n_err++; $display("FAIL reset_src got %b want 00", bus.src); end
        n_vec++; if (bus.track_len !== 8'd0) begin n_err++; $display("FAIL reset_len got %h want 00", bus.track_len); end
        n_vec++; if (bus.rec_full !== 1'b0)  begin n_err++; $display("FAIL reset_full got %b want 0", bus.rec_full); end
        n_vec++; if (bus.play_done !== 2'b0) begin n_err++; $display("FAIL reset_done got %b want 00", bus.play_done); end
        resetn = 1'b1;
        cyc(1);
        $display("reset: outputs checked");
    endtask

    task automatic test_record();
        bus.rec_track = 1'b0;
        bus.rec_en    = 1'b1;
        cyc(1);
        bus.key_pressed = key_of(1);
        cyc(1);
        n_vec++; if (bus.note !== 4'd1)   begin n_err++; $display("FAIL live_note got %0d want 1", bus.note); end
        n_vec++; if (bus.led !== 3'b001)  begin n_err++; $display("FAIL live_led got %b want 001", bus.led); end
        n_vec++; if (bus.src !== 2'b01)   begin n_err++; $display("FAIL live_src got %b want 01", bus.src); end
        bus.key_pressed = 9'd0;        cyc(1);
        bus.key_pressed = key_of(3);   cyc(1);
        bus.key_pressed = 9'd0;        cyc(1);
        bus.key_pressed = key_of(3);   cyc(1);
        bus.key_pressed = 9'd0;        cyc(1);
        bus.key_pressed = key_of(9);   cyc(1);
        bus.key_pressed = 9'd0;        cyc(1);
        n_vec++; if (bus.track_len[3:0] !== 4'd4) begin n_err++; $display("FAIL rec_len4 got %0d want 4", bus.track_len[3:0]); end
        bus.key_pressed = key_of(2);
        cyc(10);
        n_vec++; if (bus.track_len[3:0] !== 4'd5) begin n_err++; $display("FAIL hold_len got %0d want 5", bus.track_len[3:0]); end
        n_vec++; if (bus.note !== 4'd2)           begin n_err++; $display("FAIL hold_note got %0d want 2", bus.note); end
        bus.key_pressed = 9'd0;
        bus.rec_en      = 1'b0;
        cyc(1);
        n_vec++; if (bus.track_len[3:0] !== 4'd5) begin n_err++; $display("FAIL stop_len got %0d want 5", bus.track_len[3:0]); end
        $display("record: len1=%0d", bus.track_len[3:0]);
    endtask

    task automatic test_full();
        bus.rec_track = 1'b1;
        bus.rec_en    = 1'b1;
        cyc(1);
        for (int i = 0; i < 11; i++) begin
            bus.key_pressed = key_of((i % 9) + 1);
            cyc(1);
            if (i == 8) begin
                n_vec++; if (bus.rec_full !== 1'b1)        begin n_err++; $display("FAIL full_flag9 got %b want 1", bus.rec_full); end
                n_vec++; if (bus.track_len[7:4] !== 4'd9)  begin n_err++; $display("FAIL full_len9 got %0d want 9", bus.track_len[7:4]); end
            end
        end
        bus.key_pressed = 9'd0;
        cyc(1);
        n_vec++; if (bus.track_len[7:4] !== 4'd9) begin n_err++; $display("FAIL full_len11 got %0d want 9", bus.track_len[7:4]); end
        n_vec++; if (bus.rec_full !== 1'b1)       begin n_err++; $display("FAIL full_flag11 got %b want 1", bus.rec_full); end
        n_vec++; if (bus.track_len[3:0] !== 4'd5) begin n_err++; $display("FAIL full_len1 got %0d want 5", bus.track_len[3:0]); end
        bus.rec_en = 1'b0;
        cyc(1);
        n_vec++; if (bus.rec_full !== 1'b0)       begin n_err++; $display("FAIL full_clear got %b want 0", bus.rec_full); end
        $display("full: len2=%0d", bus.track_len[7:4]);
    endtask

    task automatic load_track1();
        bus.rec_track = 1'b0;
        bus.rec_en    = 1'b1;
        cyc(1);
        for (int i = 0; i < 4; i++) begin
            bus.key_pressed = key_of(int'(seq1[i])); cyc(1);
            bus.key_pressed = 9'd0;                  cyc(1);
        end
        bus.rec_en = 1'b0;
        cyc(1);
        n_vec++; if (bus.track_len[3:0] !== 4'd4) begin n_err++; $display("FAIL load_len got %0d want 4", bus.track_len[3:0]); end
    endtask

    task automatic test_playback();
        exp_t e;
        load_track1();
        bus.loop_en = 1'b0;
        bus.play_en = 2'b01;
        for (int j = 0; j < 21; j++) begin
            e.note = (j == 0) ? 4'd0 : (j <= 4) ? 4'd1 : (j <= 12) ? 4'd3 : (j <= 16) ? 4'd9 : 4'd0;
            e.src  = (e.note != 4'd0) ? 2'b10 : 2'b00;
            e.done = (j == 16) ? 2'b01 : 2'b00;
            sb.push_back(e);
        end
        for (int j = 0; j < 21; j++) begin
            cyc(1);
            if (sb.size() == 0) begin
                n_vec++; n_err++; $display("FAIL play_sb_empty got 0 entries want 1");
            end else begin
                e = sb.pop_front();
                n_vec++; if (bus.note !== e.note)         begin n_err++; $display("FAIL play_note[%0d] got %0d want %0d", j, bus.note, e.note); end
                n_vec++; if (bus.led !== led_of(e.note))  begin n_err++; $display("FAIL play_led[%0d] got %b want %b", j, bus.led, led_of(e.note)); end
                n_vec++; if (bus.src !== e.src)           begin n_err++; $display("FAIL play_src[%0d] got %b want %b", j, bus.src, e.src); end
                n_vec++; if (bus.play_done !== e.done)    begin n_err++; $display("FAIL play_done[%0d] got %b want %b", j, bus.play_done, e.done); end
            end
            $display("playback sample %0d note=%0d led=%b src=%b done=%b", j, bus.note, bus.led, bus.src, bus.play_done);
        end
        bus.play_en = 2'b00;
        cyc(1);
    endtask

    task automatic test_loop_arb();
        exp_t e;
        logic live;
        bus.loop_en = 1'b1;
        bus.play_en = 2'b11;
        e = '0;
        sb.push_back(e);
        for (int k = 0; k < 45; k++) begin
            cyc(1);
            if (sb.size() == 0) begin
                n_vec++; n_err++; $display("FAIL loop_sb_empty got 0 entries want 1");
            end else begin
                e = sb.pop_front();
                n_vec++; if (bus.note !== e.note)        begin n_err++; $display("FAIL loop_note[%0d] got %0d want %0d", k, bus.note, e.note); end
                n_vec++; if (bus.led !== led_of(e.note)) begin n_err++; $display("FAIL loop_led[%0d] got %b want %b", k, bus.led, led_of(e.note)); end
                n_vec++; if (bus.src !== e.src)          begin n_err++; $display("FAIL loop_src[%0d] got %b want %b", k, bus.src, e.src); end
                n_vec++; if (bus.play_done !== e.done)   begin n_err++; $display("FAIL loop_done[%0d] got %b want %b", k, bus.play_done, e.done); end
            end
            $display("loop sample %0d note=%0d src=%b", k, bus.note, bus.src);
            if (k < 44) begin
                live = (k >= 21) && (k <= 23);
                bus.key_pressed = live ? key_of(4) : 9'd0;
                bus.play_en     = (k < 30) ? 2'b11 : 2'b10;
                e.done = 2'b00;
                if (live) begin
                    e.note = 4'd4;
                    e.src  = 2'b01;
                end else if (k <= 30) begin
                    e.note = seq1[(k >> 2) & 3];
                    e.src  = 2'b10;
                end else begin
                    e.note = 4'(((k >> 2) % 9) + 1);
                    e.src  = 2'b11;
                end
                sb.push_back(e);
            end
        end
        bus.play_en = 2'b00;
        bus.loop_en = 1'b0;
        cyc(1);
    endtask

    task automatic test_rec_over_play();
        bus.loop_en = 1'b1;
        bus.play_en = 2'b01;
        cyc(6);
        bus.rec_track = 1'b0;
        bus.rec_en    = 1'b1;
        cyc(1);
        n_vec++; if (bus.track_len[3:0] !== 4'd0) begin n_err++; $display("FAIL rop_len1 got %0d want 0", bus.track_len[3:0]); end
        n_vec++; if (bus.track_len[7:4] !== 4'd9) begin n_err++; $display("FAIL rop_len2 got %0d want 9", bus.track_len[7:4]); end
        n_vec++; if (bus.play_done !== 2'b00)     begin n_err++; $display("FAIL rop_done1 got %b want 00", bus.play_done); end
        cyc(1);
        n_vec++; if (bus.note !== 4'd0)           begin n_err++; $display("FAIL rop_note got %0d want 0", bus.note); end
        n_vec++; if (bus.src !== 2'b00)           begin n_err++; $display("FAIL rop_src got %b want 00", bus.src); end
        n_vec++; if (bus.play_done !== 2'b00)     begin n_err++; $display("FAIL rop_done2 got %b want 00", bus.play_done); end
        bus.rec_en  = 1'b0;
        bus.play_en = 2'b00;
        bus.loop_en = 1'b0;
        cyc(1);
        $display("record over play: len1=%0d note=%0d", bus.track_len[3:0], bus.note);
    endtask

    task automatic test_async_reset();
        bus.loop_en = 1'b1;
        bus.play_en = 2'b10;
        cyc(8);
        n_vec++; if (bus.note !== 4'd2)  begin n_err++; $display("FAIL ar_pre_note got %0d want 2", bus.note); end
        n_vec++; if (bus.src !== 2'b11)  begin n_err++; $display("FAIL ar_pre_src got %b want 11", bus.src); end
        #2 resetn = 1'b0;
        #1;
        n_vec++; if (bus.note !== 4'd0)      begin n_err++; $display("FAIL ar_note got %0d want 0", bus.note); end
        n_vec++; if (bus.led !== 3'b000)     begin n_err++; $display("FAIL ar_led got %b want 000", bus.led); end
        n_vec++; if (bus.src !== 2'b00)      begin n_err++; $display("FAIL ar_src got %b want 00", bus.src); end
        n_vec++; if (bus.track_len !== 8'd0) begin n_err++; $display("FAIL ar_len got %h want 00", bus.track_len); end
        n_vec++; if (bus.rec_full !== 1'b0)  begin n_err++; $display("FAIL ar_full got %b want 0", bus.rec_full); end
        n_vec++; if (bus.play_done !== 2'b0) begin n_err++; $display("FAIL ar_done got %b want 00", bus.play_done); end
        @(negedge clk);
        bus.play_en = 2'b00;
        bus.loop_en = 1'b0;
        resetn      = 1'b1;
        cyc(1);
        bus.play_en = 2'b01;
        cyc(3);
        n_vec++; if (bus.note !== 4'd0)      begin n_err++; $display("FAIL ar_post_note got %0d want 0", bus.note); end
        n_vec++; if (bus.src !== 2'b00)      begin n_err++; $display("FAIL ar_post_src got %b want 00", bus.src); end
        n_vec++; if (bus.track_len !== 8'd0) begin n_err++; $display("FAIL ar_post_len got %h want 00", bus.track_len); end
        n_vec++; if (bus.play_done !== 2'b0) begin n_err++; $display("FAIL ar_post_done got %b want 00", bus.play_done); end
        bus.play_en = 2'b00;
        cyc(1);
        $display("async reset: outputs checked");
    endtask

    initial begin
        test_reset();
        test_record();
        test_full();
        test_playback();
        test_loop_arb();
        test_rec_over_play();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
